// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Phase sequencer for a two-way intersection. Each TICK pulse (one per second)
// advances the phase counter. The base loop is
//   NS_GRN -> NS_YEL -> RED_1 -> EW_GRN -> EW_YEL -> RED_2 -> NS_GRN.
// A phase lasts exactly its configured number of ticks: the counter is loaded
// with duration-1 on entry and the phase ends on a tick that finds it at zero.
//
// Optional feature, macro TRAFFIC_PED_EN:
//   defined   - a latched pedestrian request inserts PED_WALK after the next
//               all-red phase; PED_ACK pulses once per latched request.
//   undefined - i_ped_req is ignored, o_walk and o_ped_ack are tied to 0 and
//               only the six-state base loop runs.
//
// Ports:
//   i_clk        system clock, all logic on posedge
//   i_rst_n      asynchronous active-low reset
//   i_tick       one-cycle-per-second pulse (a held level counts every cycle)
//   i_ped_req    pedestrian button level, already synchronized
//   o_ns_light   NS lamps {red, yellow, green}, one-hot
//   o_ew_light   EW lamps {red, yellow, green}, one-hot
//   o_walk       pedestrian walk lamp
//   o_ped_ack    one-cycle pulse when a request is latched
//   o_remain     ticks remaining in the current phase, minus one
//   o_state      current FSM state encoding, for observation
//
// There is no valid/ready handshake here: i_tick and o_ped_ack are plain
// single-cycle pulses, each meaningful on the cycle it is high.
// -----------------------------------------------------------------------------
module traffic_phase_ctrl #(
    parameter int GREEN_S  = 10,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 1,
    parameter int WALK_S   = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_ped_req,
    output logic [2:0] o_ns_light,
    output logic [2:0] o_ew_light,
    output logic       o_walk,
    output logic       o_ped_ack,
    output logic [7:0] o_remain,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        NS_GRN   = 3'd0,
        NS_YEL   = 3'd1,
        RED_1    = 3'd2,
        EW_GRN   = 3'd3,
        EW_YEL   = 3'd4,
        RED_2    = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [2:0] r_ns;
    logic [2:0] r_ew;
    logic [2:0] w_ns_nxt;
    logic [2:0] w_ew_nxt;
    logic       w_phase_end;
    logic       w_walk_go;

    // Counter reload value for a phase: duration-1, so 256 maps to 8'hFF.
    function automatic logic [7:0] dur_m1(input state_t s);
        case (s)
            NS_GRN, EW_GRN: dur_m1 = 8'(GREEN_S - 1);
            NS_YEL, EW_YEL: dur_m1 = 8'(YELLOW_S - 1);
            PED_WALK:       dur_m1 = 8'(WALK_S - 1);
            default:        dur_m1 = 8'(ALLRED_S - 1);
        endcase
    endfunction

    assign w_phase_end = i_tick && (r_cnt == 8'd0);

`ifdef TRAFFIC_PED_EN
    logic r_pend;
    logic r_dir_ew;   // next green after the walk is EW (walk followed RED_1)
    logic r_walk;
    logic r_ack;
    logic w_req_set;

    assign w_req_set = i_ped_req && !r_pend && (r_state != PED_WALK);
    // Uses the registered pend flag, so a request latched on the very edge an
    // all-red phase ends waits for the next all-red.
    assign w_walk_go = w_phase_end && r_pend &&
                       ((r_state == RED_1) || (r_state == RED_2));
`else
    logic w_unused_ped;

    assign w_unused_ped = i_ped_req;
    assign w_walk_go    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_tick) begin
            if (r_cnt == 8'd0) begin
                case (r_state)
                    NS_GRN:   w_state_nxt = NS_YEL;
                    NS_YEL:   w_state_nxt = RED_1;
                    RED_1:    w_state_nxt = w_walk_go ? PED_WALK : EW_GRN;
                    EW_GRN:   w_state_nxt = EW_YEL;
                    EW_YEL:   w_state_nxt = RED_2;
                    RED_2:    w_state_nxt = w_walk_go ? PED_WALK : NS_GRN;
`ifdef TRAFFIC_PED_EN
                    PED_WALK: w_state_nxt = r_dir_ew ? EW_GRN : NS_GRN;
`endif
                    default:  w_state_nxt = NS_GRN;
                endcase
                w_cnt_nxt = dur_m1(w_state_nxt);
            end else begin
                w_cnt_nxt = r_cnt - 8'd1;
            end
        end

        // Lamps are decoded from the next state so they register together
        // with the state itself.
        w_ns_nxt = LAMP_RED;
        w_ew_nxt = LAMP_RED;
        case (w_state_nxt)
            NS_GRN:  w_ns_nxt = LAMP_GRN;
            NS_YEL:  w_ns_nxt = LAMP_YEL;
            EW_GRN:  w_ew_nxt = LAMP_GRN;
            EW_YEL:  w_ew_nxt = LAMP_YEL;
            default: begin
                w_ns_nxt = LAMP_RED;
                w_ew_nxt = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RED_2;
            r_cnt   <= 8'(ALLRED_S - 1);
            r_ns    <= LAMP_RED;
            r_ew    <= LAMP_RED;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ns    <= w_ns_nxt;
            r_ew    <= w_ew_nxt;
        end
    end

`ifdef TRAFFIC_PED_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend   <= 1'b0;
            r_dir_ew <= 1'b0;
            r_walk   <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            if (w_walk_go) begin
                r_pend   <= 1'b0;
                r_dir_ew <= (r_state == RED_1);
            end else if (w_req_set) begin
                r_pend <= 1'b1;
            end
            r_walk <= (w_state_nxt == PED_WALK);
            r_ack  <= w_req_set;
        end
    end

    assign o_walk    = r_walk;
    assign o_ped_ack = r_ack;
`else
    assign o_walk    = 1'b0;
    assign o_ped_ack = 1'b0;
`endif

    assign o_ns_light = r_ns;
    assign o_ew_light = r_ew;
    assign o_remain   = r_cnt;
    assign o_state    = r_state;

endmodule
